// File: rtl/dmc_pkg.sv
// -----------------------------------------------------------------------------
// dmc_pkg
// Shared constants and helper functions for the delay_match_checker block.
//   LAT_MIN / LAT_MAX : legal range of the latency parameter
//   NUM_CH_MAX        : widest channel vector the helpers accept
//   popcount()        : number of set bits in a 32-bit vector
//   lowest_idx()      : index of the lowest set bit (0 when the vector is 0)
// -----------------------------------------------------------------------------
package dmc_pkg;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 16;
    localparam int NUM_CH_MAX = 32;

    function automatic logic [5:0] popcount(input logic [NUM_CH_MAX-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH_MAX; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    // Scans from the top down so the last hit, the lowest index, is kept.
    function automatic logic [4:0] lowest_idx(input logic [NUM_CH_MAX-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_CH_MAX - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmc_delay_pipe.sv
// -----------------------------------------------------------------------------
// dmc_delay_pipe
// LAT-stage shift register for a DW-bit data word with a parallel valid bit.
// Synchronous active-high reset clears both data and valid stages.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   i_vld   in   valid bit entering stage 1
//   i_data  in   DW-bit word entering stage 1
//   o_vld   out  valid bit of stage LAT
//   o_data  out  data word of stage LAT
// -----------------------------------------------------------------------------
module dmc_delay_pipe
    import dmc_pkg::*;
#(
    parameter int DW  = 1,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0]  r_data [LAT];
    logic [LAT-1:0] r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data stages are reset as well as the valid bits so a
            // flushed pipeline is fully deterministic; this prevents RAM
            // inference, which is acceptable for a LAT*DW shift register.
            for (int i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
            r_vld <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its
            // neighbour's pre-edge value, giving a true shift register.
            r_data[0] <= i_data;
            r_vld[0]  <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    assign o_data = r_data[LAT-1];
    assign o_vld  = r_vld[LAT-1];

endmodule

// File: rtl/delay_match_checker.sv
// -----------------------------------------------------------------------------
// delay_match_checker
// Checks that each of NUM_CH actual channels reproduces its expected channel
// exactly LAT cycles later. Reports per-channel pulses and sticky flags, a
// saturating mismatch counter and a capture of the first mismatch.
// Optional feature: define DMC_CH_MASK_EN to add a per-channel ch_mask input
// that suppresses all reporting for masked channels.
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   chk_en         in   qualifies exp_in this cycle as a checked sample
//   exp_in         in   expected values, channel c at [c*W +: W]
//   act_in         in   actual values, same packing
//   ch_mask        in   (DMC_CH_MASK_EN only) 1 = channel ignored
//   clr_err        in   clears sticky, counter and first-error capture
//   err_pulse      out  registered one-cycle mismatch strobe per channel
//   err_sticky     out  latched mismatch per channel
//   err_cnt        out  saturating total mismatch count
//   first_err_vld  out  first-error capture valid
//   first_err_ch   out  channel of first mismatch
//   first_err_exp  out  expected value at first mismatch
//   first_err_act  out  actual value at first mismatch
// -----------------------------------------------------------------------------
module delay_match_checker
    import dmc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int W      = 1,
    parameter int LAT    = 2,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                chk_en,
    input  logic [NUM_CH*W-1:0] exp_in,
    input  logic [NUM_CH*W-1:0] act_in,
`ifdef DMC_CH_MASK_EN
    input  logic [NUM_CH-1:0]   ch_mask,
`endif
    input  logic                clr_err,
    output logic [NUM_CH-1:0]   err_pulse,
    output logic [NUM_CH-1:0]   err_sticky,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                first_err_vld,
    output logic [CH_W-1:0]     first_err_ch,
    output logic [W-1:0]        first_err_exp,
    output logic [W-1:0]        first_err_act
);

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("delay_match_checker: LAT must be within 1..16");
    end
    if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("delay_match_checker: NUM_CH must be within 1..32");
    end

    localparam logic [CNT_W+5:0] CNT_MAX_EXT = {6'd0, {CNT_W{1'b1}}};

    logic                w_pipe_vld;
    logic [NUM_CH*W-1:0] w_pipe_exp;

    dmc_delay_pipe #(
        .DW  (NUM_CH * W),
        .LAT (LAT)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (chk_en),
        .i_data (exp_in),
        .o_vld  (w_pipe_vld),
        .o_data (w_pipe_exp)
    );

    // Mismatch vector for this edge: only a valid matured entry may flag.
    logic [NUM_CH-1:0] w_raw_mis;
    logic [NUM_CH-1:0] w_mis;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_raw_mis[c] = w_pipe_vld && (act_in[c*W +: W] != w_pipe_exp[c*W +: W]);
        end
    end

`ifdef DMC_CH_MASK_EN
    assign w_mis = w_raw_mis & ~ch_mask;
`else
    assign w_mis = w_raw_mis;
`endif

    logic [NUM_CH-1:0] r_pulse;
    logic [NUM_CH-1:0] r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_first_vld;
    logic [CH_W-1:0]   r_first_ch;
    logic [W-1:0]      r_first_exp;
    logic [W-1:0]      r_first_act;

    logic [CH_W-1:0]   w_first_idx;
    logic [CNT_W+5:0]  w_cnt_sum;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [NUM_CH-1:0] w_sticky_next;
    logic              w_first_vld_next;
    logic [CH_W-1:0]   w_first_ch_next;
    logic [W-1:0]      w_first_exp_next;
    logic [W-1:0]      w_first_act_next;

    // clr_err is applied to the current state first; this cycle's mismatches
    // are then merged on top of the cleared (or held) values.
    always_comb begin
        // NOTE: every signal gets a default before any branch so this block
        // can never infer a latch.
        w_first_idx      = CH_W'(lowest_idx(NUM_CH_MAX'(w_mis)));
        w_cnt_sum        = (clr_err ? '0 : {6'd0, r_cnt}) + (CNT_W+6)'(popcount(NUM_CH_MAX'(w_mis)));
        w_cnt_next       = (w_cnt_sum > CNT_MAX_EXT) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        w_sticky_next    = (clr_err ? '0 : r_sticky) | w_mis;
        w_first_vld_next = clr_err ? 1'b0 : r_first_vld;
        w_first_ch_next  = clr_err ? '0   : r_first_ch;
        w_first_exp_next = clr_err ? '0   : r_first_exp;
        w_first_act_next = clr_err ? '0   : r_first_act;

        if (!w_first_vld_next && (|w_mis)) begin
            w_first_vld_next = 1'b1;
            w_first_ch_next  = w_first_idx;
            w_first_exp_next = w_pipe_exp[w_first_idx*W +: W];
            w_first_act_next = act_in[w_first_idx*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse     <= '0;
            r_sticky    <= '0;
            r_cnt       <= '0;
            r_first_vld <= 1'b0;
            r_first_ch  <= '0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else begin
            r_pulse     <= w_mis;
            r_sticky    <= w_sticky_next;
            r_cnt       <= w_cnt_next;
            r_first_vld <= w_first_vld_next;
            r_first_ch  <= w_first_ch_next;
            r_first_exp <= w_first_exp_next;
            r_first_act <= w_first_act_next;
        end
    end

    assign err_pulse     = r_pulse;
    assign err_sticky    = r_sticky;
    assign err_cnt       = r_cnt;
    assign first_err_vld = r_first_vld;
    assign first_err_ch  = r_first_ch;
    assign first_err_exp = r_first_exp;
    assign first_err_act = r_first_act;

endmodule

// File: tb/tb_delay_match_checker.sv
// -----------------------------------------------------------------------------
// tb_delay_match_checker
// Directed bench for delay_match_checker with NUM_CH=4, W=8, LAT=2, CNT_W=3.
// The actual stream is the expected stream delayed two cycles, optionally
// XOR-corrupted per step. The mask steps are built only with DMC_CH_MASK_EN.
// -----------------------------------------------------------------------------
module tb_delay_match_checker;

    localparam int NUM_CH = 4;
    localparam int W      = 8;
    localparam int LAT    = 2;
    localparam int CNT_W  = 3;

    logic                clk;
    logic                rst;
    logic                chk_en;
    logic [NUM_CH*W-1:0] exp_in;
    logic [NUM_CH*W-1:0] act_in;
    logic                clr_err;
    logic [NUM_CH-1:0]   err_pulse;
    logic [NUM_CH-1:0]   err_sticky;
    logic [CNT_W-1:0]    err_cnt;
    logic                first_err_vld;
    logic [1:0]          first_err_ch;
    logic [W-1:0]        first_err_exp;
    logic [W-1:0]        first_err_act;
`ifdef DMC_CH_MASK_EN
    logic [NUM_CH-1:0]   ch_mask;
`endif

    delay_match_checker #(
        .NUM_CH (NUM_CH),
        .W      (W),
        .LAT    (LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chk_en        (chk_en),
        .exp_in        (exp_in),
        .act_in        (act_in),
`ifdef DMC_CH_MASK_EN
        .ch_mask       (ch_mask),
`endif
        .clr_err       (clr_err),
        .err_pulse     (err_pulse),
        .err_sticky    (err_sticky),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_ch  (first_err_ch),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected values seen on the two previous edges; d2 is what act_in must
    // carry on the coming edge to be a match.
    logic [31:0] d1;
    logic [31:0] d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 ns, advance history.
    task automatic cyc(input logic [31:0] e, input logic en, input logic [31:0] xm);
        exp_in = e;
        chk_en = en;
        act_in = d2 ^ xm;
        @(posedge clk);
        #1;
        d2 = d1;
        d1 = e;
    endtask

    logic [31:0] e_saved;
    logic [7:0]  b_saved;

    initial begin
        rst     = 1'b1;
        clr_err = 1'b0;
        chk_en  = 1'b0;
        exp_in  = '0;
        act_in  = '0;
        d1      = '0;
        d2      = '0;
`ifdef DMC_CH_MASK_EN
        ch_mask = '0;
`endif

        // Reset state
        cyc(32'h0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 32'h0);
        cyc(32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        check("rst_pulse",  32'(err_pulse),     32'h0);
        check("rst_sticky", 32'(err_sticky),    32'h0);
        check("rst_cnt",    32'(err_cnt),       32'h0);
        check("rst_vld",    32'(first_err_vld), 32'h0);
        check("rst_ch",     32'(first_err_ch),  32'h0);
        check("rst_exp",    32'(first_err_exp), 32'h0);
        check("rst_act",    32'(first_err_act), 32'h0);

        // Exact match for 100 random cycles
        for (int i = 0; i < 100; i++) begin
            cyc($urandom, 1'b1, 32'h0);
            check("match_pulse", 32'(err_pulse), 32'h0);
        end
        check("match_cnt",    32'(err_cnt),       32'h0);
        check("match_sticky", 32'(err_sticky),    32'h0);
        check("match_vld",    32'(first_err_vld), 32'h0);

        // Single fault: ch2 expected A5, actual 5A
        e_saved = $urandom;
        e_saved[23:16] = 8'hA5;
        cyc(e_saved, 1'b1, 32'h0);
        cyc($urandom, 1'b1, 32'h0);
        check("single_early_pulse", 32'(err_pulse), 32'h0);
        cyc($urandom, 1'b1, 32'h00FF_0000);
        check("single_pulse",  32'(err_pulse),     32'h4);
        check("single_cnt",    32'(err_cnt),       32'h1);
        check("single_vld",    32'(first_err_vld), 32'h1);
        check("single_ch",     32'(first_err_ch),  32'h2);
        check("single_exp",    32'(first_err_exp), 32'hA5);
        check("single_act",    32'(first_err_act), 32'h5A);
        check("single_sticky", 32'(err_sticky),    32'h4);
        cyc($urandom, 1'b1, 32'h0);
        check("single_pulse_gone", 32'(err_pulse),  32'h0);
        check("single_sticky_hold", 32'(err_sticky), 32'h4);
        check("single_cnt_hold",   32'(err_cnt),    32'h1);

        // Plain clear
        clr_err = 1'b1;
        cyc($urandom, 1'b1, 32'h0);
        clr_err = 1'b0;
        check("clr_cnt",    32'(err_cnt),       32'h0);
        check("clr_sticky", 32'(err_sticky),    32'h0);
        check("clr_vld",    32'(first_err_vld), 32'h0);

        // Simultaneous faults on ch1 (xor 0F) and ch3 (xor 3C)
        e_saved = $urandom;
        cyc(e_saved, 1'b1, 32'h0);
        cyc($urandom, 1'b1, 32'h0);
        cyc($urandom, 1'b1, 32'h3C00_0F00);
        check("dual_pulse",  32'(err_pulse),     32'hA);
        check("dual_cnt",    32'(err_cnt),       32'h2);
        check("dual_vld",    32'(first_err_vld), 32'h1);
        check("dual_ch",     32'(first_err_ch),  32'h1);
        check("dual_exp",    32'(first_err_exp), 32'(e_saved[15:8]));
        check("dual_act",    32'(first_err_act), 32'(e_saved[15:8] ^ 8'h0F));
        check("dual_sticky", 32'(err_sticky),    32'hA);

        // Gap in chk_en: garbage compared against an unqualified entry
        cyc($urandom, 1'b0, 32'h0);
        cyc($urandom, 1'b1, 32'h0);
        cyc($urandom, 1'b1, 32'hFFFF_FFFF);
        check("gap_pulse", 32'(err_pulse), 32'h0);
        check("gap_cnt",   32'(err_cnt),   32'h2);
        cyc($urandom, 1'b1, 32'h0);
        check("gap_after_pulse", 32'(err_pulse), 32'h0);

        // Reset mid-stream, then garbage for two cycles after release
        rst = 1'b1;
        cyc($urandom, 1'b1, 32'hFFFF_FFFF);
        rst = 1'b0;
        check("mrst_pulse",  32'(err_pulse),     32'h0);
        check("mrst_cnt",    32'(err_cnt),       32'h0);
        check("mrst_sticky", 32'(err_sticky),    32'h0);
        check("mrst_vld",    32'(first_err_vld), 32'h0);
        cyc($urandom, 1'b1, 32'hFFFF_FFFF);
        check("warm1_pulse", 32'(err_pulse), 32'h0);
        cyc($urandom, 1'b1, 32'hFFFF_FFFF);
        check("warm2_pulse", 32'(err_pulse), 32'h0);
        check("warm2_cnt",   32'(err_cnt),   32'h0);
        cyc($urandom, 1'b1, 32'h0);
        check("warm3_pulse", 32'(err_pulse), 32'h0);
        cyc($urandom, 1'b1, 32'h0000_00FF);
        check("warm4_pulse", 32'(err_pulse), 32'h1);
        check("warm4_cnt",   32'(err_cnt),   32'h1);

        // Saturation: ten ch3 mismatches into a 3-bit counter
        clr_err = 1'b1;
        cyc($urandom, 1'b1, 32'h0);
        clr_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc($urandom, 1'b1, 32'hFF00_0000);
            check("sat_cnt", 32'(err_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        check("sat_sticky", 32'(err_sticky),   32'h8);
        check("sat_ch",     32'(first_err_ch), 32'h3);

        // clr_err in the same cycle as a ch0 mismatch
        b_saved = d2[7:0];
        clr_err = 1'b1;
        cyc($urandom, 1'b1, 32'h0000_00FF);
        clr_err = 1'b0;
        check("clrmis_pulse",  32'(err_pulse),     32'h1);
        check("clrmis_cnt",    32'(err_cnt),       32'h1);
        check("clrmis_sticky", 32'(err_sticky),    32'h1);
        check("clrmis_vld",    32'(first_err_vld), 32'h1);
        check("clrmis_ch",     32'(first_err_ch),  32'h0);
        check("clrmis_exp",    32'(first_err_exp), 32'(b_saved));
        check("clrmis_act",    32'(first_err_act), 32'(b_saved ^ 8'hFF));

`ifdef DMC_CH_MASK_EN
        // ch1 masked then unmasked
        ch_mask = 4'b0010;
        cyc($urandom, 1'b1, 32'h0000_FF00);
        check("mask_pulse", 32'(err_pulse),  32'h0);
        check("mask_cnt",   32'(err_cnt),    32'h1);
        check("mask_sticky", 32'(err_sticky), 32'h1);
        ch_mask = 4'b0000;
        cyc($urandom, 1'b1, 32'h0000_FF00);
        check("unmask_pulse", 32'(err_pulse), 32'h2);
        check("unmask_cnt",   32'(err_cnt),   32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
